// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline and the RV32M multiply/divide sequencer.
interface muldiv_if;
    logic        StartE;
    logic [2:0]  MulDivOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        StallMD;
    logic        BusyE;
    logic        MDValidE;
    logic [31:0] MDResultE;

    modport master (
        output StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
        input  StallMD, BusyE, MDValidE, MDResultE
    );

    modport slave (
        input  StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
        output StallMD, BusyE, MDValidE, MDResultE
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide on magnitudes.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 multiply.
//
// state | meaning
// IDLE  | waiting for an accepted M op; result register holds last value
// CALC  | one multiply/divide iteration per cycle, counter 0..31
// DONE  | MDValidE strobe for one cycle, then back to IDLE
module muldiv_sequencer (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] acc, q, b, result;
    logic [4:0]  cnt;
    logic [2:0]  op;
    logic        neg;

    logic        accept, is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [31:0] a_mag, b_mag;
    logic        sc;
    logic [31:0] sc_val;
    logic [32:0] rem_sh, sum;
    logic [31:0] acc_it, q_it, div_val, res_fin;
    logic [63:0] prod;

    assign accept   = (state == IDLE) && bus.StartE && !bus.FlushE;
    assign is_div   = bus.MulDivOpE[2];
    assign a_signed = (bus.MulDivOpE == 3'b001) || (bus.MulDivOpE == 3'b010) ||
                      (bus.MulDivOpE == 3'b100) || (bus.MulDivOpE == 3'b110);
    assign b_signed = (bus.MulDivOpE == 3'b001) || (bus.MulDivOpE == 3'b100) ||
                      (bus.MulDivOpE == 3'b110);
    assign a_neg    = a_signed && bus.SrcAE[31];
    assign b_neg    = b_signed && bus.SrcBE[31];
    assign a_mag    = a_neg ? -bus.SrcAE : bus.SrcAE;
    assign b_mag    = b_neg ? -bus.SrcBE : bus.SrcBE;
    // Remainder takes the dividend's sign; quotient and products take the XOR.
    assign neg_in   = (is_div && bus.MulDivOpE[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] ax, bx, pf;
    assign ax = {{31{a_neg}}, a_neg, bus.SrcAE};
    assign bx = {{31{b_neg}}, b_neg, bus.SrcBE};
    assign pf = ax * bx;
`endif

    always_comb begin
        sc     = 1'b0;
        sc_val = 32'h0;
        if (is_div && bus.SrcBE == 32'h0) begin
            sc     = 1'b1;
            sc_val = bus.MulDivOpE[1] ? bus.SrcAE : 32'hFFFF_FFFF;
        end else if (is_div && !bus.MulDivOpE[0] &&
                     bus.SrcAE == 32'h8000_0000 && bus.SrcBE == 32'hFFFF_FFFF) begin
            sc     = 1'b1;
            sc_val = bus.MulDivOpE[1] ? 32'h0 : 32'h8000_0000;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div) begin
            sc     = 1'b1;
            sc_val = (bus.MulDivOpE[1:0] == 2'b00) ? pf[31:0] : pf[63:32];
        end
`endif
    end

    always_comb begin
        rem_sh  = {acc, q[31]};
        sum     = {1'b0, acc} + {1'b0, (q[0] ? b : 32'h0)};
        acc_it  = acc;
        q_it    = q;
        prod    = 64'h0;
        div_val = 32'h0;
        res_fin = 32'h0;
        if (op[2]) begin
            if (rem_sh >= {1'b0, b}) begin
                acc_it = rem_sh[31:0] - b;
                q_it   = {q[30:0], 1'b1};
            end else begin
                acc_it = rem_sh[31:0];
                q_it   = {q[30:0], 1'b0};
            end
            div_val = op[1] ? acc_it : q_it;
            res_fin = neg ? -div_val : div_val;
        end else begin
            acc_it  = sum[32:1];
            q_it    = {sum[0], q[31:1]};
            prod    = {acc_it, q_it};
            if (neg)
                prod = -prod;
            res_fin = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = sc ? DONE : CALC;
            CALC: begin
                if (bus.FlushE)
                    state_nx = IDLE;
                else if (cnt == 5'd31)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= 32'h0;
            q      <= 32'h0;
            b      <= 32'h0;
            op     <= 3'h0;
            neg    <= 1'b0;
            cnt    <= 5'h0;
            result <= 32'h0;
        end else if (accept) begin
            acc <= 32'h0;
            q   <= a_mag;
            b   <= b_mag;
            op  <= bus.MulDivOpE;
            neg <= neg_in;
            cnt <= 5'h0;
            if (sc)
                result <= sc_val;
        end else if (state == CALC) begin
            acc <= acc_it;
            q   <= q_it;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31 && !bus.FlushE)
                result <= res_fin;
        end
    end

    always_comb begin
        bus.StallMD   = accept || (state == CALC && !bus.FlushE);
        bus.BusyE     = (state != IDLE);
        bus.MDValidE  = (state == DONE) && !bus.FlushE;
        bus.MDResultE = result;
    end
endmodule
